// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared types and sizes for the 4-digit segment scan driver.
//   NUM_DIGITS  : digits on the multiplexed display
//   SEG_W       : segments per digit (a..g, no decimal point)
//   DIGIT_W     : width of the digit index
//   DIV_CNT_W   : width of the prescaler counter (covers CLK_DIV up to 65535)
//   seg_code_t  : one 7-segment code, bit=1 means segment lit
//   seg_frame_t : one displayable frame: four codes plus its drop flag
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;
   localparam int DIGIT_W    = $clog2(NUM_DIGITS);
   localparam int DIV_CNT_W  = 16;

   typedef logic [SEG_W-1:0] seg_code_t;

   typedef struct packed {
      seg_code_t [NUM_DIGITS-1:0] codes;
      logic                       drop;
   } seg_frame_t;

endpackage

// File: rtl/seg_scan_driver_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running divider that sets the per-digit hold time of the scan.
// div_cnt runs 0..CLK_DIV-1 and wraps; tick is high on the last count.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (div_cnt -> 0)
//   tick   out  high for one cycle every CLK_DIV cycles
// -----------------------------------------------------------------------------
module scan_prescaler
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   logic [DIV_CNT_W-1:0] div_cnt;

   assign tick = (div_cnt == DIV_CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Buffers one frame of four 7-segment codes plus a drop flag behind a
// valid/ready handshake and time-multiplexes the codes onto one shared
// segment bus with one-hot digit enables for a 4-digit display.
//
// Frames are accepted into a single shadow slot and promoted to the active
// (displayed) frame only at a scan-frame boundary, so a frame is never torn
// mid-scan. Without a pending frame the active one repeats forever.
//
// Optional build macro SEG_SCAN_DROP_BLINK_EN: while the displayed frame has
// its drop flag set, the digits blink with a half-period of BLINK_FRAMES scan
// frames. Undefined: the display is always on.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   in_valid       in   upstream frame valid
//   in_ready       out  shadow slot empty, frame can be accepted
//   seven_seg1..4  in   digit 0..3 codes, bit=1 means segment lit
//   drop_activated in   drop flag belonging to the frame
//   seg_out        out  shared segment bus, polarity per ACTIVE_LOW
//   an             out  one-hot digit enable, polarity per ACTIVE_LOW
//   drop_led       out  drop flag of the displayed frame, active-high
//   frame_done     out  one-cycle pulse after each scan-frame boundary
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV      = 1000,
   parameter int ACTIVE_LOW   = 1,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEG_W-1:0]      seven_seg1,
   input  logic [SEG_W-1:0]      seven_seg2,
   input  logic [SEG_W-1:0]      seven_seg3,
   input  logic [SEG_W-1:0]      seven_seg4,
   input  logic                  drop_activated,
   output logic [SEG_W-1:0]      seg_out,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  drop_led,
   output logic                  frame_done
);

   // Map logical "lit"/"enabled" levels onto the board's pin polarity.
   function automatic seg_code_t drive_seg(input seg_code_t lit);
      return (ACTIVE_LOW != 0) ? ~lit : lit;
   endfunction

   function automatic logic [NUM_DIGITS-1:0] drive_an(input logic [NUM_DIGITS-1:0] en);
      return (ACTIVE_LOW != 0) ? ~en : en;
   endfunction

   logic               tick;
   logic [DIGIT_W-1:0] digit_idx;
   logic               boundary;
   logic               capture;
   logic               transfer;
   logic               blank;

   seg_frame_t         shadow_q;
   logic               shadow_full;
   seg_frame_t         active_q;

   logic [SEG_W-1:0]      seg_p1;
   logic [NUM_DIGITS-1:0] an_p1;
   logic                  frame_done_p1;
   logic [NUM_DIGITS-1:0] an_sel;

   scan_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign boundary = tick && (digit_idx == DIGIT_W'(NUM_DIGITS - 1));
   assign in_ready = !shadow_full;
   assign capture  = in_valid && in_ready;
   // Capture needs an empty slot and transfer a full one, so they never
   // coincide; a boundary with a full slot therefore blocks capture.
   assign transfer = boundary && shadow_full;

   // Digit scan, shadow slot and active frame. digit_idx wraps 3->0 on the
   // boundary tick by itself, so a transferred frame starts at digit 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit_idx     <= '0;
         shadow_full   <= 1'b0;
         active_q      <= '0;
         frame_done_p1 <= 1'b0;
      end else begin
         frame_done_p1 <= boundary;
         if (tick) begin
            digit_idx <= digit_idx + DIGIT_W'(1);
         end
         if (transfer) begin
            active_q    <= shadow_q;
            shadow_full <= 1'b0;
         end else if (capture) begin
            shadow_full <= 1'b1;
         end
      end
   end

   // Shadow data needs no reset: it is only read once shadow_full is set.
   always_ff @(posedge clk) begin
      if (rst_n && capture) begin
         shadow_q.codes[0] <= seven_seg1;
         shadow_q.codes[1] <= seven_seg2;
         shadow_q.codes[2] <= seven_seg3;
         shadow_q.codes[3] <= seven_seg4;
         shadow_q.drop     <= drop_activated;
      end
   end

`ifdef SEG_SCAN_DROP_BLINK_EN
   logic [15:0] frame_cnt;
   logic        blink_on;

   // Counts scan frames; restarts in the visible phase whenever a frame with
   // the drop flag replaces one without it, so a new drop is seen at once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (boundary) begin
         if (transfer && !active_q.drop && shadow_q.drop) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign blank = active_q.drop && !blink_on;
`else
   logic blink_cfg_unused;
   assign blink_cfg_unused = (BLINK_FRAMES != 0);
   assign blank            = 1'b0;
`endif

   always_comb begin
      an_sel            = '0;
      an_sel[digit_idx] = 1'b1;
   end

   // Output stage: registered from digit_idx and the active frame, so the
   // pins lag digit_idx by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_p1 <= drive_seg('0);
         an_p1  <= drive_an('0);
      end else if (blank) begin
         seg_p1 <= drive_seg('0);
         an_p1  <= drive_an('0);
      end else begin
         seg_p1 <= drive_seg(active_q.codes[digit_idx]);
         an_p1  <= drive_an(an_sel);
      end
   end

   assign seg_out    = seg_p1;
   assign an         = an_p1;
   assign drop_led   = active_q.drop;
   assign frame_done = frame_done_p1;

endmodule
